// File: rtl/nf10_axis_dma_tx_arbiter.sv
// nf10_axis_dma_tx_arbiter
// Packet-level round-robin arbiter in front of the DMA-bound AXI-Stream master.
// One source is locked from its first beat until its tlast beat transfers, so the
// DMA converter never sees interleaved packets. The datapath is a combinational
// mux with no skid registers; one idle bubble cycle separates consecutive packets.
// Optional build macro NF10_AXIS_ARB_PKT_COUNT_EN adds the pkt_count output, an
// 8-bit wrapping count of tlast beats transferred on m_axis.
module nf10_axis_dma_tx_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS          = 4,
    parameter int PORT_W             = 2
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                      s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                      s_axis_tlast,
    output logic [NUM_PORTS-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
    output logic                                      m_axis_tvalid,
    output logic                                      m_axis_tlast,
    input  logic                                      m_axis_tready,
    output logic [PORT_W-1:0]                         grant_idx,
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
    output logic [7:0]                                pkt_count,
`endif
    output logic                                      busy
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PORT_W-1:0] grant_q, grant_d;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;
    logic [PORT_W-1:0] pick;
    logic              locked;
    logic              eop;

    assign locked    = (state_q == ST_LOCKED);
    assign busy      = locked;
    assign grant_idx = grant_q;
    assign eop       = locked && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Round-robin pick: first requesting port after last_grant, wrapping modulo NUM_PORTS.
    always_comb begin
        logic              found;
        logic [PORT_W-1:0] cand;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PORT_W'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!found && s_axis_tvalid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Pass-through mux: granted slice drives m_axis only while locked, zero otherwise.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (locked) begin
            m_axis_tdata  = s_axis_tdata[int'(grant_q)*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            m_axis_tstrb  = s_axis_tstrb[int'(grant_q)*STRB_W +: STRB_W];
            m_axis_tuser  = s_axis_tuser[int'(grant_q)*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
            m_axis_tvalid = s_axis_tvalid[grant_q];
            m_axis_tlast  = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    // Next-state: lock on any request, release only after the tlast beat transfers.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = pick;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (eop) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; last_grant resets to the top port so port 0 wins first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
    logic [7:0] pkt_count_q;

    // Count completed packets on m_axis; wraps naturally at 8 bits.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count_q <= 8'd0;
        end else if (eop) begin
            pkt_count_q <= pkt_count_q + 8'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_nf10_axis_dma_tx_arbiter.sv
// Directed self-checking bench for nf10_axis_dma_tx_arbiter (4 ports, 256-bit data).
// Each port is a small packet source: it offers 'quota' packets of 'len' beats,
// payload tagged with port and beat number, and may be stalled per port.
module tb_nf10_axis_dma_tx_arbiter;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NP = 4;
    localparam int SW = DW / 8;

    logic              clk;
    logic              rst_n;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*SW-1:0]  s_tstrb;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_ready;
    logic [1:0]        grant_idx;
    logic              busy;
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
    logic [7:0]        pkt_count;
`endif

    int tests = 0;
    int fails = 0;

    logic [3:0] beat  [NP];
    int         len   [NP];
    int         quota [NP];
    bit         stall [NP];
    int         sent  [NP] = '{0, 0, 0, 0};

    nf10_axis_dma_tx_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS         (NP),
        .PORT_W            (2)
    ) dut (
        .aclk         (clk),
        .aresetn      (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tstrb (s_tstrb),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tstrb (m_tstrb),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_ready),
        .grant_idx    (grant_idx),
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
        .pkt_count    (pkt_count),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdata(int p, int b);
        return {{28{8'h5A}}, 8'(p), 8'(b), 16'hBEEF};
    endfunction

    function automatic logic [UW-1:0] mkuser(int p, int b);
        return {120'h0, 4'(p), 4'(b)};
    endfunction

    // Source outputs
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p]            = (sent[p] < quota[p]) && !stall[p];
            s_tdata[p*DW +: DW]    = mkdata(p, int'(beat[p]));
            s_tuser[p*UW +: UW]    = mkuser(p, int'(beat[p]));
            s_tstrb[p*SW +: SW]    = {8{4'(p + 1)}};
            s_tlast[p]             = (int'(beat[p]) == len[p] - 1);
        end
    end

    // Source beat counters; a reset abandons any partial packet
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) beat[p] <= 4'd0;
        end else begin
            for (int p = 0; p < NP; p++)
                if (s_tvalid[p] && s_tready[p]) beat[p] <= s_tlast[p] ? 4'd0 : beat[p] + 4'd1;
        end
    end

    // Completed-packet counters per source
    always @(posedge clk) begin
        for (int p = 0; p < NP; p++)
            if (s_tvalid[p] && s_tready[p] && s_tlast[p]) sent[p] <= sent[p] + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        m_ready = 1'b1;
        quota[2] = sent[2] + 1;
        #1;
        tests++;
        if ({m_tvalid, m_tlast, busy, grant_idx, s_tready} !== 9'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp 0", {m_tvalid, m_tlast, busy, grant_idx, s_tready});
        end
        tests++;
        if ({m_tdata, m_tstrb, m_tuser} !== '0) begin
            fails++;
            $display("FAIL reset_data got nonzero m_axis payload exp 0");
        end
        quota[2] = sent[2];
        step();
        rst_n = 1'b1;
        #1;
        tests++;
        if ({busy, m_tvalid, s_tready} !== 6'b0) begin
            fails++;
            $display("FAIL reset_release got %b exp 0", {busy, m_tvalid, s_tready});
        end
        step();
    endtask

    task automatic test_single_port();
        int s0 = sent[1];
        len[1]   = 3;
        quota[1] = s0 + 1;
        #1;
        tests++;
        if ({busy, m_tvalid, s_tready} !== 6'b0) begin
            fails++;
            $display("FAIL single_bubble got %b exp 0", {busy, m_tvalid, s_tready});
        end
        step();
        for (int b = 0; b < 3; b++) begin
            #1;
            tests++;
            if ({busy, grant_idx, m_tvalid, m_tlast, s_tready} !== {1'b1, 2'd1, 1'b1, b == 2, 4'b0010}) begin
                fails++;
                $display("FAIL single_ctrl beat %0d got %b exp %b", b,
                         {busy, grant_idx, m_tvalid, m_tlast, s_tready},
                         {1'b1, 2'd1, 1'b1, b == 2, 4'b0010});
            end
            tests++;
            if (m_tdata !== mkdata(1, b) || m_tuser !== mkuser(1, b) || m_tstrb !== {8{4'h2}}) begin
                fails++;
                $display("FAIL single_data beat %0d got %h/%h exp %h/%h", b, m_tdata[31:0],
                         m_tuser[7:0], mkdata(1, b) & 256'hFFFFFFFF, mkuser(1, b) & 128'hFF);
            end
            step();
        end
        #1;
        tests++;
        if ({busy, m_tvalid, s_tready} !== 6'b0 || sent[1] !== s0 + 1) begin
            fails++;
            $display("FAIL single_done got busy=%b pkts=%0d exp busy=0 pkts=%0d", busy, sent[1] - s0, 1);
        end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < NP; p++) begin
            len[p]   = 2;
            quota[p] = sent[p] + 2;
        end
        for (int k = 0; k < 5; k++) begin
            int e = k % NP;
            #1;
            tests++;
            if ({busy, m_tvalid} !== 2'b00) begin
                fails++;
                $display("FAIL rr_bubble pkt %0d got %b exp 00", k, {busy, m_tvalid});
            end
            step();
            for (int b = 0; b < 2; b++) begin
                #1;
                tests++;
                if ({busy, grant_idx, m_tvalid, m_tlast, s_tready} !==
                    {1'b1, 2'(e), 1'b1, b == 1, 4'(1 << e)} || m_tdata !== mkdata(e, b)) begin
                    fails++;
                    $display("FAIL rr_beat pkt %0d beat %0d got grant=%0d data=%h exp grant=%0d data=%h",
                             k, b, grant_idx, m_tdata[31:0], e, mkdata(e, b) & 256'hFFFFFFFF);
                end
                step();
            end
        end
        for (int p = 0; p < NP; p++) quota[p] = sent[p];
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rr_stop got busy=%b exp 0", busy);
        end
        step();
        #1;
        tests++;
        if ({busy, m_tvalid} !== 2'b00) begin
            fails++;
            $display("FAIL rr_quiet got %b exp 00", {busy, m_tvalid});
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [4:0] rp = 5'b10101;
        int s0 = sent[2];
        int eb = 0;
        len[2]   = 3;
        quota[2] = s0 + 1;
        m_ready  = 1'b1;
        #1;
        tests++;
        if ({busy, m_tvalid} !== 2'b00) begin
            fails++;
            $display("FAIL bp_bubble got %b exp 00", {busy, m_tvalid});
        end
        step();
        for (int i = 0; i < 5; i++) begin
            m_ready = rp[i];
            #1;
            tests++;
            if ({busy, grant_idx, m_tvalid, m_tlast, s_tready} !==
                {1'b1, 2'd2, 1'b1, eb == 2, rp[i] ? 4'b0100 : 4'b0000} || m_tdata !== mkdata(2, eb)) begin
                fails++;
                $display("FAIL bp_cycle %0d got rdy=%b data=%h exp rdy=%b data=%h", i, s_tready,
                         m_tdata[31:0], rp[i] ? 4'b0100 : 4'b0000, mkdata(2, eb) & 256'hFFFFFFFF);
            end
            step();
            if (rp[i]) eb++;
        end
        m_ready = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || sent[2] !== s0 + 1) begin
            fails++;
            $display("FAIL bp_done got busy=%b pkts=%0d exp busy=0 pkts=1", busy, sent[2] - s0);
        end
        step();
    endtask

    task automatic test_stall();
        len[0]   = 3;
        len[3]   = 1;
        quota[0] = sent[0] + 1;
        #1;
        tests++;
        if ({busy, m_tvalid} !== 2'b00) begin
            fails++;
            $display("FAIL stall_bubble got %b exp 00", {busy, m_tvalid});
        end
        step();
        #1;
        tests++;
        if ({busy, grant_idx, m_tvalid} !== {1'b1, 2'd0, 1'b1} || m_tdata !== mkdata(0, 0)) begin
            fails++;
            $display("FAIL stall_first got grant=%0d valid=%b exp grant=0 valid=1", grant_idx, m_tvalid);
        end
        step();
        stall[0] = 1'b1;
        quota[3] = sent[3] + 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({busy, grant_idx, m_tvalid, s_tready} !== {1'b1, 2'd0, 1'b0, 4'b0001}) begin
                fails++;
                $display("FAIL stall_hold %0d got %b exp %b", i, {busy, grant_idx, m_tvalid, s_tready},
                         {1'b1, 2'd0, 1'b0, 4'b0001});
            end
            step();
        end
        stall[0] = 1'b0;
        for (int b = 1; b < 3; b++) begin
            #1;
            tests++;
            if ({busy, grant_idx, m_tvalid, m_tlast} !== {1'b1, 2'd0, 1'b1, b == 2} ||
                m_tdata !== mkdata(0, b)) begin
                fails++;
                $display("FAIL stall_resume beat %0d got grant=%0d data=%h exp grant=0 data=%h", b,
                         grant_idx, m_tdata[31:0], mkdata(0, b) & 256'hFFFFFFFF);
            end
            step();
        end
        #1;
        tests++;
        if ({busy, m_tvalid} !== 2'b00) begin
            fails++;
            $display("FAIL stall_gap got %b exp 00", {busy, m_tvalid});
        end
        step();
        #1;
        tests++;
        if ({busy, grant_idx, m_tvalid, m_tlast, s_tready} !== {1'b1, 2'd3, 1'b1, 1'b1, 4'b1000} ||
            m_tdata !== mkdata(3, 0)) begin
            fails++;
            $display("FAIL stall_next got grant=%0d rdy=%b exp grant=3 rdy=1000", grant_idx, s_tready);
        end
        step();
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL stall_end got busy=%b exp 0", busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int s1 = sent[1];
        len[1]   = 4;
        quota[1] = s1 + 1;
        step();
        step();
        #1;
        tests++;
        if ({busy, grant_idx, m_tvalid} !== {1'b1, 2'd1, 1'b1} || m_tdata !== mkdata(1, 1)) begin
            fails++;
            $display("FAIL rstmid_pre got grant=%0d data=%h exp grant=1 data=%h", grant_idx,
                     m_tdata[31:0], mkdata(1, 1) & 256'hFFFFFFFF);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, grant_idx, m_tvalid, m_tlast, s_tready} !== 9'b0 || m_tdata !== '0) begin
            fails++;
            $display("FAIL rstmid_async got %b exp 0", {busy, grant_idx, m_tvalid, m_tlast, s_tready});
        end
        len[0]   = 1;
        quota[0] = sent[0] + 1;
        #3;
        rst_n = 1'b1;
        #1;
        tests++;
        if ({busy, m_tvalid} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_release got %b exp 00", {busy, m_tvalid});
        end
        step();
        #1;
        tests++;
        if ({busy, grant_idx, m_tvalid, m_tlast} !== {1'b1, 2'd0, 1'b1, 1'b1} || m_tdata !== mkdata(0, 0)) begin
            fails++;
            $display("FAIL rstmid_prio got grant=%0d exp 0", grant_idx);
        end
        step();
        step();
        for (int b = 0; b < 4; b++) begin
            #1;
            tests++;
            if ({busy, grant_idx, m_tvalid, m_tlast} !== {1'b1, 2'd1, 1'b1, b == 3} ||
                m_tdata !== mkdata(1, b)) begin
                fails++;
                $display("FAIL rstmid_port1 beat %0d got grant=%0d data=%h exp grant=1 data=%h", b,
                         grant_idx, m_tdata[31:0], mkdata(1, b) & 256'hFFFFFFFF);
            end
            step();
        end
        #1;
        tests++;
        if (busy !== 1'b0 || sent[1] !== s1 + 1) begin
            fails++;
            $display("FAIL rstmid_done got busy=%b pkts=%0d exp busy=0 pkts=1", busy, sent[1] - s1);
        end
        step();
    endtask

    task automatic test_pkt_wrap();
        int s0;
        do_reset();
        s0       = sent[0];
        len[0]   = 1;
        quota[0] = s0 + 257;
        for (int k = 0; k < 257; k++) begin
            #1;
            tests++;
            if ({busy, m_tvalid} !== 2'b00) begin
                fails++;
                $display("FAIL wrap_bubble pkt %0d got %b exp 00", k, {busy, m_tvalid});
            end
            step();
            #1;
            tests++;
            if ({busy, grant_idx, m_tvalid, m_tlast, s_tready} !== {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001}) begin
                fails++;
                $display("FAIL wrap_beat pkt %0d got %b exp %b", k,
                         {busy, grant_idx, m_tvalid, m_tlast, s_tready}, {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001});
            end
            step();
        end
        #1;
        tests++;
        if (busy !== 1'b0 || sent[0] !== s0 + 257) begin
            fails++;
            $display("FAIL wrap_total got busy=%b pkts=%0d exp busy=0 pkts=257", busy, sent[0] - s0);
        end
`ifdef NF10_AXIS_ARB_PKT_COUNT_EN
        tests++;
        if (pkt_count !== 8'd1) begin
            fails++;
            $display("FAIL wrap_pkt_count got %0d exp 1", pkt_count);
        end
`endif
        step();
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            len[p]   = 1;
            quota[p] = 0;
            stall[p] = 1'b0;
        end
        test_reset();
        test_single_port();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_pkt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
